// File: rtl/ingress_wrreq_dispatch.sv
// Splits accepted ingress write packets into single-DW register writes, decoding
// each DW address into a channel/register destination and dropping undecodable DWs.
module ingress_wrreq_dispatch #(
  parameter int DATA_W = 128,
  parameter int CH_NUM = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wrreq_data,
  input  logic [9:0]        wrreq_addr,
  input  logic [9:0]        wrreq_len,
  input  logic [3:0]        wrreq_first_be,
  input  logic [3:0]        wrreq_last_be,
  input  logic              wrreq_valid,
  output logic              wrreq_rdy,
  output logic              wr_req,
  input  logic              wr_rdy,
  output logic [9:0]        wr_tdest,
  output logic [31:0]       wr_tdata,
  output logic [3:0]        wr_tbe,
  output logic              drop_err,
  output logic [15:0]       drop_cnt
);

  localparam int MAX_DW = DATA_W / 32;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic [9:0]        r_addr;
  logic [9:0]        r_len;
  logic [3:0]        r_fbe;
  logic [3:0]        r_lbe;
  logic [3:0]        r_k;
  logic [3:0]        w_k_nxt;
  logic [15:0]       r_drop_cnt;

  logic [9:0]  w_addr_k;
  logic [3:0]  w_ch;
  logic [5:0]  w_dec;
  logic        w_last;
  logic [3:0]  w_be;
  logic [31:0] w_dword;
  logic        w_bad;
  logic        w_send;
  logic        w_req;
  logic        w_dw_drop;
  logic        w_rdy;
  logic        w_accept;
  logic        w_len_bad;
  logic        w_pkt_drop;
  logic        w_adv;
  logic        w_unused;

  // Returns {valid, reg[2:0], dir[1:0]}; dir 00 = TX, 01 = RX.
  function automatic logic [5:0] dec_off(input logic [3:0] off);
    case (off)
      4'b0000: dec_off = 6'b1_011_01;
      4'b0001: dec_off = 6'b1_100_01;
      4'b0010: dec_off = 6'b1_101_01;
      4'b0011: dec_off = 6'b1_000_01;
      4'b0100: dec_off = 6'b1_001_01;
      4'b0101: dec_off = 6'b1_011_00;
      4'b0110: dec_off = 6'b1_100_00;
      4'b0111: dec_off = 6'b1_101_00;
      default: dec_off = 6'b0_000_00;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Per-DW decode of the captured packet at index r_k.
  always_comb begin
    w_addr_k = r_addr + {4'b0000, r_k, 2'b00};
    w_ch     = w_addr_k[9:6];
    w_dec    = dec_off(w_addr_k[5:2]);
    w_last   = ({6'b0, r_k} == (r_len - 10'd1));
    if (r_k == 4'd0)
      w_be = r_fbe;
    else if (w_last)
      w_be = r_lbe;
    else
      w_be = 4'hF;
    w_dword = 32'h0;
    for (int i = 0; i < MAX_DW; i++) begin
      if (r_k == 4'(i))
        w_dword = r_data[32*i +: 32];
    end
    w_bad = !w_dec[5] || ({1'b0, w_ch} >= 5'(CH_NUM)) || (w_be == 4'h0);
  end

  assign w_unused   = &{1'b0, w_addr_k[1:0]};
  assign w_send     = (r_state == S_SEND) && !rst;
  assign w_req      = w_send && !w_bad;
  assign w_dw_drop  = w_send && w_bad;
  assign w_rdy      = (r_state == S_IDLE) && !rst;
  assign w_accept   = wrreq_valid && w_rdy;
  assign w_len_bad  = (wrreq_len == 10'd0) || (wrreq_len > 10'(MAX_DW));
  assign w_pkt_drop = w_accept && w_len_bad;
  assign w_adv      = (w_req && wr_rdy) || w_dw_drop;

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_len_bad) begin
          w_state_nxt = S_SEND;
          w_k_nxt     = 4'd0;
        end
      end
      S_SEND: begin
        if (w_adv) begin
          w_k_nxt = r_k + 4'd1;
          if (w_last)
            w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_k        <= 4'd0;
      r_drop_cnt <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      if (w_pkt_drop || w_dw_drop)
        r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  // Payload capture carries no reset; outputs are gated by state instead.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_data <= wrreq_data;
      r_addr <= wrreq_addr;
      r_len  <= wrreq_len;
      r_fbe  <= wrreq_first_be;
      r_lbe  <= wrreq_last_be;
    end
  end

  assign wrreq_rdy = w_rdy;
  assign wr_req    = w_req;
  assign wr_tdest  = w_req ? {1'b0, w_dec[4:0], w_ch} : 10'h000;
  assign wr_tdata  = w_req ? w_dword : 32'h0;
  assign wr_tbe    = w_req ? w_be : 4'h0;
  assign drop_err  = w_pkt_drop || w_dw_drop;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_ingress_wrreq_dispatch.sv
// Scoreboard bench for ingress_wrreq_dispatch: directed scenarios plus random
// packets, checked against a packet-level reference model.
module tb_ingress_wrreq_dispatch;

  localparam int DATA_W = 128;
  localparam int CH_NUM = 12;
  localparam int MAX_DW = DATA_W / 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] wrreq_data;
  logic [9:0]        wrreq_addr;
  logic [9:0]        wrreq_len;
  logic [3:0]        wrreq_first_be;
  logic [3:0]        wrreq_last_be;
  logic              wrreq_valid;
  logic              wrreq_rdy;
  logic              wr_req;
  logic              wr_rdy;
  logic [9:0]        wr_tdest;
  logic [31:0]       wr_tdata;
  logic [3:0]        wr_tbe;
  logic              drop_err;
  logic [15:0]       drop_cnt;

  logic rdy_rand  = 1'b0;
  logic rdy_force = 1'b1;
  logic rnd_bit   = 1'b1;
  assign wr_rdy = rdy_rand ? rnd_bit : rdy_force;

  typedef struct packed {
    logic [9:0]  tdest;
    logic [31:0] tdata;
    logic [3:0]  tbe;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  exp_pulses = 0;
  int  mon_pulses = 0;
  int  exp_cnt = 0;

  ingress_wrreq_dispatch #(.DATA_W(DATA_W), .CH_NUM(CH_NUM)) dut (
    .clk(clk), .rst(rst),
    .wrreq_data(wrreq_data), .wrreq_addr(wrreq_addr), .wrreq_len(wrreq_len),
    .wrreq_first_be(wrreq_first_be), .wrreq_last_be(wrreq_last_be),
    .wrreq_valid(wrreq_valid), .wrreq_rdy(wrreq_rdy),
    .wr_req(wr_req), .wr_rdy(wr_rdy), .wr_tdest(wr_tdest), .wr_tdata(wr_tdata),
    .wr_tbe(wr_tbe), .drop_err(drop_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1 rnd_bit = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Offset -> register map: TX offsets 5..7 hit regs 3..5; RX offsets 0..4 hit regs 3,4,5,0,1.
  function automatic bit ref_map(input int off, output int rg, output int dr);
    rg = 0; dr = 0;
    if (off >= 5 && off <= 7) begin rg = off - 2; dr = 0; return 1'b1; end
    if (off <= 4) begin rg = (off + 3) % 8; dr = 1; if (rg > 5) rg = rg - 6; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic void note_drop();
    exp_pulses++;
    if (exp_cnt < 65535) exp_cnt++;
  endfunction

  function automatic void model_pkt(input logic [DATA_W-1:0] d, input int addr, input int len,
                                    input int fbe, input int lbe);
    int a, ch, off, be, rg, dr;
    wr_t e;
    if (len == 0 || len > MAX_DW) begin note_drop(); return; end
    for (int k = 0; k < len; k++) begin
      a   = (addr + 4 * k) % 1024;
      ch  = a / 64;
      off = (a / 4) % 16;
      be  = (k == 0) ? fbe : ((k == len - 1) ? lbe : 15);
      if (!ref_map(off, rg, dr) || ch >= CH_NUM || be == 0) note_drop();
      else begin
        e.tdest = {1'b0, 3'(rg), 2'(dr), 4'(ch)};
        e.tdata = d[32*k +: 32];
        e.tbe   = 4'(be);
        exp_q.push_back(e);
      end
    end
  endfunction

  // Monitor: pops the scoreboard on every transfer and checks holds under backpressure.
  initial begin
    wr_t e;
    wr_t prev;
    logic prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (drop_err) mon_pulses++;
      if (!rst && prev_stall) begin
        chk("hold_req", wr_req, 1'b1);
        chk("hold_tdest", wr_tdest, prev.tdest);
        chk("hold_tdata", wr_tdata, prev.tdata);
        chk("hold_tbe", wr_tbe, prev.tbe);
      end
      if (wr_req && wr_rdy) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_wr: tdest=%h tdata=%h tbe=%h with nothing expected",
                   wr_tdest, wr_tdata, wr_tbe);
        end else begin
          e = exp_q.pop_front();
          chk("wr_tdest", wr_tdest, e.tdest);
          chk("wr_tdata", wr_tdata, e.tdata);
          chk("wr_tbe", wr_tbe, e.tbe);
        end
      end
      prev_stall = wr_req && !wr_rdy && !rst;
      prev = '{tdest: wr_tdest, tdata: wr_tdata, tbe: wr_tbe};
    end
  end

  task automatic send_pkt(input logic [DATA_W-1:0] d, input logic [9:0] a, input logic [9:0] l,
                          input logic [3:0] fb, input logic [3:0] lb);
    int w;
    @(posedge clk);
    #1;
    wrreq_data = d; wrreq_addr = a; wrreq_len = l;
    wrreq_first_be = fb; wrreq_last_be = lb; wrreq_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!wrreq_rdy && w < 300) begin @(negedge clk); w++; end
    if (!wrreq_rdy) begin
      chk("accept_timeout", wrreq_rdy, 1'b1);
      wrreq_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_pkt(d, int'(a), int'(l), int'(fb), int'(lb));
    #1 wrreq_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && wrreq_rdy) && w < 300) begin @(negedge clk); w++; end
    chk({tag, "_drain"}, exp_q.size(), 0);
    chk({tag, "_rdy"}, wrreq_rdy, 1'b1);
    chk({tag, "_pulses"}, mon_pulses, exp_pulses);
    chk({tag, "_cnt"}, drop_cnt, exp_cnt);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"}, wrreq_rdy, 1'b0);
    chk({tag, "_req"}, wr_req, 1'b0);
    chk({tag, "_tdest"}, wr_tdest, 10'h0);
    chk({tag, "_tdata"}, wr_tdata, 32'h0);
    chk({tag, "_tbe"}, wr_tbe, 4'h0);
    chk({tag, "_drop_err"}, drop_err, 1'b0);
    chk({tag, "_drop_cnt"}, drop_cnt, 16'h0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero(tag);
    exp_cnt = 0;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk({tag, "_rdy_after"}, wrreq_rdy, 1'b1);
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < MAX_DW; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d;
    logic [9:0] a, l;
    logic [3:0] fb, lb;
    rst = 1'b1;
    wrreq_data = '0; wrreq_addr = '0; wrreq_len = '0;
    wrreq_first_be = '0; wrreq_last_be = '0; wrreq_valid = 1'b0;
    do_reset("reset");

    // Single DW to channel 3 RX reg 100.
    d = rnd_data();
    d[31:0] = 32'hA5A5_0001;
    send_pkt(d, 10'h0C4, 10'd1, 4'hF, 4'h0);
    @(negedge clk);
    chk("single_req", wr_req, 1'b1);
    chk("single_tdest", wr_tdest, 10'b0_100_01_0011);
    chk("single_tdata", wr_tdata, 32'hA5A5_0001);
    chk("single_tbe", wr_tbe, 4'hF);
    wait_idle("single");

    // Four-DW burst: wrreq_rdy stays low for exactly four cycles.
    send_pkt(rnd_data(), 10'h000, 10'd4, 4'hF, 4'h3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("burst_rdy_low", wrreq_rdy, 1'b0);
    end
    @(negedge clk);
    chk("burst_rdy_back", wrreq_rdy, 1'b1);
    wait_idle("burst");

    // Backpressure on DW1 of a two-DW burst.
    send_pkt(rnd_data(), 10'h140, 10'd2, 4'hF, 4'hF);
    @(posedge clk);
    #1 rdy_force = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("bp_req_held", wr_req, 1'b1);
    @(posedge clk);
    #1 rdy_force = 1'b1;
    wait_idle("bp");

    // Drops: bad channel, oversize packet, undecodable offset mid-burst.
    send_pkt(rnd_data(), 10'h300, 10'd1, 4'hF, 4'hF);
    wait_idle("drop_ch");
    chk("drop_ch_cnt1", drop_cnt, 16'd1);
    send_pkt(rnd_data(), 10'h000, 10'd5, 4'hF, 4'hF);
    wait_idle("drop_len");
    chk("drop_len_cnt2", drop_cnt, 16'd2);
    send_pkt(rnd_data(), 10'h058, 10'd3, 4'hF, 4'hF);
    wait_idle("drop_off");
    chk("drop_off_cnt3", drop_cnt, 16'd3);

    // Reset during DW2 of a four-DW burst.
    send_pkt(rnd_data(), 10'h000, 10'd4, 4'hF, 4'hF);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rstmid_req", wr_req, 1'b0);
    chk("rstmid_sent_two", exp_q.size(), 2);
    exp_q.delete();
    exp_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    chk_zero("rstmid");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_rdy_after", wrreq_rdy, 1'b1);
    send_pkt(rnd_data(), 10'h0C4, 10'd1, 4'hF, 4'hF);
    wait_idle("after_rst");

    // Random packets with random backpressure.
    rdy_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      l  = 10'($urandom_range(0, MAX_DW + 1));
      a  = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 9)), 2'b00};
      fb = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      lb = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      send_pkt(rnd_data(), a, l, fb, lb);
    end
    wait_idle("random");
    rdy_rand = 1'b0;

    // Saturation: drive 0xFFFE zero-length drops, then push past the limit.
    do_reset("sat_reset");
    @(posedge clk);
    #1 wrreq_len = 10'd0; wrreq_valid = 1'b1;
    repeat (65534) @(posedge clk);
    exp_pulses += 65534;
    exp_cnt += 65534;
    #1 wrreq_valid = 1'b0;
    @(negedge clk);
    chk("sat_fffe", drop_cnt, 16'hFFFE);
    send_pkt(rnd_data(), 10'h000, 10'd0, 4'hF, 4'hF);
    send_pkt(rnd_data(), 10'h300, 10'd1, 4'hF, 4'hF);
    wait_idle("sat_two");
    chk("sat_ffff", drop_cnt, 16'hFFFF);
    send_pkt(rnd_data(), 10'h000, 10'd0, 4'hF, 4'hF);
    wait_idle("sat_stay");
    chk("sat_stay_ffff", drop_cnt, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ingress_wrreq_dispatch.md
INGRESS_WRREQ_DISPATCH -- requirements
Module: ingress_wrreq_dispatch

Interface
REQ-001 Parameter DATA_W, default 128: ingress payload width in bits; one of 64, 128, 256.
REQ-002 Parameter CH_NUM, default 12: implemented DMA channels; range 1..16.
REQ-003 Derived constant MAX_DW = DATA_W/32: maximum DWs per write packet.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 wrreq_data  in  DATA_W  payload; DW k at bits [32k+31:32k].
REQ-007 wrreq_addr  in  10  byte address {channel[9:6], offset[5:2], zero[1:0]}.
REQ-008 wrreq_len  in  10  payload length in DWs.
REQ-009 wrreq_first_be / wrreq_last_be  in  4 each  TLP first/last DW byte enables.
REQ-010 wrreq_valid  in  1, wrreq_rdy  out  1: packet handshake; transfer when both high.
REQ-011 wr_req  out  1, wr_rdy  in  1: register-write handshake; transfer when both high.
REQ-012 wr_tdest  out  10  {unused[9], reg[8:6], dir[5:4], channel[3:0]}; dir 00 = TX, 01 = RX.
REQ-013 wr_tdata  out  32; wr_tbe  out  4: write data and byte enables.
REQ-014 drop_err  out  1: one-cycle pulse per dropped DW or packet.
REQ-015 drop_cnt  out  16: saturating drop counter.

Function
REQ-016 The FSM SHALL have two states: IDLE and SEND.
REQ-017 wrreq_rdy SHALL be 1 only in IDLE.
REQ-018 On acceptance in IDLE, capture data, addr, len, first_be and last_be, set index k = 0, and enter SEND.
REQ-019 If wrreq_len == 0 or wrreq_len > MAX_DW, drop the whole packet, pulse drop_err once, increment drop_cnt once, and stay in IDLE.
REQ-020 In SEND, DW k SHALL use address (addr + 4k) mod 1024, data DW k, and byte enable:
  - k == 0: first_be
  - k == len-1 with len > 1: last_be
  - otherwise: 4'hF
REQ-021 Offset decode to {reg, dir}:
  - TX: 0101->{011,00}, 0110->{100,00}, 0111->{101,00}
  - RX: 0000->{011,01}, 0001->{100,01}, 0010->{101,01}, 0011->{000,01}, 0100->{001,01}
REQ-022 A DW SHALL be dropped, with a drop_err pulse and drop_cnt++, and consumes one cycle without asserting wr_req, if any of these hold:
  - offset is 1000..1111
  - channel >= CH_NUM
  - byte enable == 0
REQ-023 A valid DW SHALL present wr_req = 1 with stable wr_tdest, wr_tdata and wr_tbe until wr_rdy; k advances only on transfer or drop.
REQ-024 Latency: a packet accepted at cycle N SHALL present its first wr_req at cycle N+1; with wr_rdy held high, one DW issues per cycle.
REQ-025 After the last DW (k == len-1) transfers or drops, return to IDLE; wrreq_rdy SHALL be high the following cycle.
REQ-026 wr_tdest[9] SHALL be 0.
REQ-027 drop_cnt SHALL saturate at 16'hFFFF.
REQ-028 When drops coincide, at most one increment occurs per cycle.

Reset
REQ-029 On rst, all outputs SHALL go to 0 and the FSM to IDLE.
REQ-030 Reset mid-SEND SHALL discard the remaining DWs; wrreq_rdy = 1 on the first cycle after rst deasserts.

Verification
REQ-031 Single DW, addr 0x0C4 (ch 3, off 0001), data 0xA5A5_0001, first_be F, wr_rdy = 1 -> next cycle wr_req = 1, tdest = {0,100,01,0011}, tdata 0xA5A5_0001, tbe F.
REQ-032 Burst, len 4, addr 0x000 (ch 0, off 0), first_be F, last_be 3 -> four consecutive writes to offsets 0..3, tdest regs 011, 100, 101, 000 with dir 01, last tbe 3; wrreq_rdy low for 4 cycles.
REQ-033 Backpressure: wr_rdy low for 5 cycles during DW1 of a 2-DW burst -> wr_req, tdest and tdata held unchanged; DW1 issues on the first wr_rdy high.
REQ-034 Drops, CH_NUM = 12:
  - addr 0x300 (ch 12) -> no wr_req, drop_err pulse, drop_cnt = 1
  - len 5 with DATA_W = 128 -> packet dropped, drop_cnt = 2
  - offset 1000 inside a 3-DW burst -> only that DW is dropped
REQ-035 Assert rst during DW2 of a 4-DW burst -> all outputs 0, no further wr_req, next packet is accepted normally.
REQ-036 Saturation: force drop_cnt to 16'hFFFE, then two drops -> drop_cnt reads 16'hFFFF and stays there.
